fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter for the 16x256 asynchronous FIFO (fifo_16x256); runs in the write clock domain.
//  Shares the single FIFO write port between NUM_REQ valid/ready packet streams.
//  Holds each grant for a whole packet, so packets from different requesters never interleave.
//  Throttles on the FIFO almost_full flag (threshold 252); the FIFO never receives a write while full.
// PARAMETERS
//  NUM_REQ      2    number of requesters, 2..8
//  DATA_WIDTH   16   beat width; must equal the FIFO WR_DATA_WIDTH
//  MAX_PKT_LEN  64   beats per packet before forced truncation, 2..255
// PORTS
//  clk               in   1                    clock (FIFO wr_clk)
//  rst_n             in   1                    asynchronous, active-low reset
//  req_valid         in   NUM_REQ              per-requester beat valid
//  req_data          in   NUM_REQ*DATA_WIDTH   requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last          in   NUM_REQ              final beat of the packet
//  req_ready         out  NUM_REQ              beat accepted when valid&ready
//  fifo_wr_en        out  1                    to FIFO wr_en
//  fifo_wr_data      out  DATA_WIDTH           to FIFO wr_data
//  fifo_almost_full  in   1                    from FIFO almost_full
//  fifo_wr_full      in   1                    from FIFO wr_full
//  grant_id          out  clog2(NUM_REQ) (min 1)  index of the current or last granted requester
//  busy              out  1                    high in the XFER state
//  pkt_trunc         out  1                    1-cycle pulse on forced packet end
//  pkt_cnt           out  16                   completed packets; wraps
// BEHAVIOUR
//  Reset values: all outputs 0; rr_ptr = 0; state = IDLE.
//  States:
//   IDLE: if any req_valid, select the first set bit searching upward (modulo NUM_REQ) from rr_ptr.
//    Latch it into grant_id and go to XFER.
//    This costs 1 arbitration bubble cycle; req_ready stays 0 in IDLE.
//   XFER: req_ready[grant_id] = !fifo_almost_full & !fifo_wr_full (combinational).
//    All other req_ready bits are 0.
//  Accepted beat (valid & ready on grant_id):
//   fifo_wr_en <= 1 and fifo_wr_data <= req_data slice on the next edge (registered, 1-cycle latency).
//   Otherwise fifo_wr_en <= 0 and fifo_wr_data holds its value.
//  Beat counter: 8-bit beat_cnt clears on entering XFER and increments per accepted beat.
//  Packet end: accepted beat with req_last=1, or beat_cnt == MAX_PKT_LEN-1 on an accepted beat.
//   Next state IDLE; rr_ptr <= grant_id+1 (mod NUM_REQ); pkt_cnt++.
//   If the end was forced (last=0), pkt_trunc pulses for 1 cycle.
//   The requester's remaining beats form a new packet and re-arbitrate.
//  Full margin: almost_full asserts at 252 entries. Registered write adds at most 1 in-flight beat,
//   so a write while wr_full=1 is a bug; the bench flags it.
//  Granted requester drops valid mid-packet: stay in XFER, no writes, no timeout.
//  Simultaneous requests: the round-robin order is strict. With all requesters always valid,
//   grants rotate 0,1,..,NUM_REQ-1,0.
//  Single requester: back-to-back packets still pay 1 IDLE cycle each.
//  rst_n low mid-packet: the in-flight registered beat is discarded (fifo_wr_en forced 0 immediately).
//   The partial packet stays in the FIFO; the requester must resynchronise.
//  pkt_cnt wraps 0xFFFF -> 0x0000.
// TESTING
//  T1 single packet: req0 sends 4 beats 0xA000..0xA003, last on beat 4
//   -> fifo_wr_en high 4 cycles starting 2 cycles after req_valid rises; data in order; pkt_cnt=1.
//  T2 contention: req0 and req1 both valid with 3-beat packets, rr_ptr=0
//   -> FIFO sees req0 packet then req1 packet, never interleaved; grant_id 0 then 1; rr_ptr=0 at end.
//  T3 backpressure: stall FIFO reads; one requester streams 300 beats in 3-beat packets
//   -> writes stop at 252-253 entries; wr_full never high during fifo_wr_en; resumes after reads drain.
//  T4 truncation: MAX_PKT_LEN=8, req1 sends 10 beats with no last
//   -> pkt_trunc pulses after beat 8; beats 9-10 form a new packet; pkt_cnt += 1 per forced end.
//  T5 reset mid-packet: rst_n low for 3 cycles at beat 2 of a 5-beat packet
//   -> all outputs 0 while low; after release, IDLE with rr_ptr=0; next packet arbitrates normally.
//  T6 fairness soak: NUM_REQ=4, all always valid with random lengths 1-16, 10k packets
//   -> per-requester packet counts differ by at most 1; FIFO output matches a per-packet reference model.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-atomic arbiter sharing the fifo_16x256 write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_PKT_LEN = 64,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_almost_full,
  input  logic                          fifo_wr_full,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          pkt_trunc,
  output logic [15:0]                   pkt_cnt
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [GW-1:0] rr_ptr, sel, nxt;
  logic [7:0] beat_cnt;
  logic open, acc, last, done;
  int j;
  // lowest offset from rr_ptr wins, so scan offsets downward and let the last hit stand
  always_comb begin
    sel = rr_ptr;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) sel = GW'(j);
    end
  end
  always_comb begin
    open = state == XFER && !fifo_almost_full && !fifo_wr_full;
    req_ready = open ? NUM_REQ'(1) << grant_id : '0;
    acc = open && req_valid[grant_id];
    last = req_last[grant_id];
    done = acc && (last || beat_cnt == 8'(MAX_PKT_LEN - 1));
    nxt = grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    busy = state == XFER;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wr_data <= '0;
      pkt_trunc <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      fifo_wr_en <= acc;
      if (acc) fifo_wr_data <= req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      pkt_trunc <= done && !last;
      if (state == IDLE) begin
        if (|req_valid) begin
          grant_id <= sel;
          beat_cnt <= '0;
          state <= XFER;
        end
      end else if (done) begin
        state <= IDLE;
        rr_ptr <= nxt;
        pkt_cnt <= pkt_cnt + 1'b1;
      end else if (acc) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench with queue-driven requesters and a FIFO occupancy model
module tb_fifo_wr_arbiter;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0, req_last = 0, req_ready;
  logic [31:0] req_data = 0;
  logic fifo_wr_en, fifo_almost_full = 0, fifo_wr_full = 0;
  logic [15:0] fifo_wr_data, pkt_cnt;
  logic [0:0] grant_id;
  logic busy, pkt_trunc;
  int total = 0, bad = 0;
  logic [16:0] q0[$], q1[$];
  logic [15:0] wlog[$], want[$];
  int wcyc[$], glog[$];
  int cyc = 0, lvl = 0, wf = 0, trunc_n = 0;
  bit drain = 1, wr_pend = 0, busy_q = 0;
  logic [1:0] acc = 0;

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(16), .MAX_PKT_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_almost_full(fifo_almost_full),
    .fifo_wr_full(fifo_wr_full), .grant_id(grant_id), .busy(busy),
    .pkt_trunc(pkt_trunc), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp_v);
    end
  endtask

  // one clock: FIFO model update, write/grant logging, requester handshake
  task automatic tick();
    @(negedge clk);
    cyc++;
    lvl = drain ? 0 : lvl + int'(wr_pend);
    fifo_almost_full = lvl >= 252;
    fifo_wr_full = lvl >= 256;
    wr_pend = fifo_wr_en;
    if (fifo_wr_en) begin
      wlog.push_back(fifo_wr_data);
      wcyc.push_back(cyc);
      if (fifo_wr_full) wf++;
    end
    if (busy && !busy_q) glog.push_back(int'(grant_id));
    busy_q = busy;
    trunc_n += int'(pkt_trunc);
    if (acc[0]) q0.delete(0);
    if (acc[1]) q1.delete(0);
    req_valid = {q1.size() > 0, q0.size() > 0};
    req_data = {q1.size() > 0 ? q1[0][15:0] : 16'h0, q0.size() > 0 ? q0[0][15:0] : 16'h0};
    req_last = {q1.size() > 0 ? q1[0][16] : 1'b0, q0.size() > 0 ? q0[0][16] : 1'b0};
    #1 acc = req_valid & req_ready;
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, n < 2000, 1);
    repeat (3) tick();
  endtask

  task automatic cmp_log(input string tag);
    int e = 0;
    chk({tag, "_len"}, wlog.size(), want.size());
    for (int i = 0; i < want.size() && i < wlog.size(); i++) if (wlog[i] !== want[i]) e++;
    chk({tag, "_data"}, e, 0);
  endtask

  task automatic clr();
    wlog.delete();
    wcyc.delete();
    glog.delete();
    want.delete();
  endtask

  initial begin
    int c0, n0, n1, g0, g1, len;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", pkt_trunc, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    rst_n = 1;
    // single 4-beat packet from req0
    clr();
    for (int i = 0; i < 4; i++) q0.push_back({i == 3, 16'hA000 + 16'(i)});
    for (int i = 0; i < 4; i++) want.push_back(16'hA000 + 16'(i));
    c0 = cyc + 1;
    run_idle("t1");
    cmp_log("t1");
    chk("t1_first_wr_cyc", wcyc.size() > 0 ? wcyc[0] : -1, c0 + 2);
    chk("t1_last_wr_cyc", wcyc.size() > 3 ? wcyc[3] : -1, c0 + 5);
    chk("t1_pkt_cnt", pkt_cnt, 1);
    chk("t1_grants", glog.size(), 1);
    chk("t1_grant0", glog.size() > 0 ? glog[0] : -1, 0);
    // single beat from req1 returns rr_ptr to 0, then contention
    clr();
    q1.push_back({1'b1, 16'hD000});
    run_idle("t2a");
    for (int i = 0; i < 3; i++) q0.push_back({i == 2, 16'hB000 + 16'(i)});
    for (int i = 0; i < 3; i++) q1.push_back({i == 2, 16'hC000 + 16'(i)});
    want = '{16'hD000, 16'hB000, 16'hB001, 16'hB002, 16'hC000, 16'hC001, 16'hC002};
    run_idle("t2b");
    cmp_log("t2");
    chk("t2_grants", glog.size(), 3);
    chk("t2_g1", glog.size() > 1 ? glog[1] : -1, 0);
    chk("t2_g2", glog.size() > 2 ? glog[2] : -1, 1);
    chk("t2_pkt_cnt", pkt_cnt, 4);
    chk("t2_trunc", trunc_n, 0);
    // 10 beats with no last: forced end after 8, tail waits in XFER
    clr();
    for (int i = 0; i < 10; i++) q1.push_back({1'b0, 16'hE000 + 16'(i)});
    for (int i = 0; i < 10; i++) want.push_back(16'hE000 + 16'(i));
    repeat (20) tick();
    cmp_log("t4");
    chk("t4_trunc", trunc_n, 1);
    chk("t4_pkt_cnt", pkt_cnt, 5);
    chk("t4_busy_hold", busy, 1);
    chk("t4_ready_hold", req_ready, 2'b10);
    chk("t4_grants", glog.size(), 2);
    chk("t4_g1", glog.size() > 1 ? glog[1] : -1, 1);
    q1.push_back({1'b1, 16'hE00A});
    want.push_back(16'hE00A);
    run_idle("t4b");
    cmp_log("t4b");
    chk("t4b_pkt_cnt", pkt_cnt, 6);
    chk("t4b_trunc", trunc_n, 1);
    // backpressure: reads stalled, 300 beats in 3-beat packets
    clr();
    drain = 0;
    for (int i = 0; i < 300; i++) q0.push_back({i % 3 == 2, 16'(i)});
    for (int i = 0; i < 300; i++) want.push_back(16'(i));
    repeat (450) tick();
    chk("t3_peak_range", lvl >= 252 && lvl <= 253, 1);
    chk("t3_stalled_count", wlog.size(), lvl);
    chk("t3_ready_low", req_ready, 0);
    drain = 1;
    run_idle("t3");
    cmp_log("t3");
    chk("t3_wr_while_full", wf, 0);
    chk("t3_pkt_cnt", pkt_cnt, 106);
    // reset at beat 2 of a 5-beat packet (rr_ptr is 1 beforehand)
    clr();
    for (int i = 0; i < 5; i++) q0.push_back({i == 4, 16'h5000 + 16'(i)});
    repeat (4) tick();
    chk("t5_pre_writes", wlog.size(), 2);
    chk("t5_pre_wr_en", fifo_wr_en, 1);
    rst_n = 0;
    #1;
    chk("t5_wr_en", fifo_wr_en, 0);
    chk("t5_wr_data", fifo_wr_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_pkt_cnt", pkt_cnt, 0);
    q0.delete();
    acc = 0;
    repeat (3) begin
      tick();
      chk("t5_hold_wr_en", fifo_wr_en, 0);
    end
    rst_n = 1;
    clr();
    q0.push_back({1'b1, 16'h6000});
    q1.push_back({1'b1, 16'h7000});
    want = '{16'h6000, 16'h7000};
    run_idle("t5");
    cmp_log("t5");
    chk("t5_grants", glog.size(), 2);
    chk("t5_g0", glog.size() > 0 ? glog[0] : -1, 0);
    chk("t5_post_pkt_cnt", pkt_cnt, 2);
    // fairness: both always valid, random lengths 1..8, strict alternation expected
    clr();
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        q0.push_back({i == len - 1, 16'h8000 | 16'(n0)});
        want.push_back(16'h8000 | 16'(n0));
        n0++;
      end
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        q1.push_back({i == len - 1, 16'hC000 | 16'(n1)});
        want.push_back(16'hC000 | 16'(n1));
        n1++;
      end
    end
    run_idle("t6");
    cmp_log("t6");
    g0 = 0;
    g1 = 0;
    foreach (glog[i]) if (glog[i] == 0) g0++; else g1++;
    chk("t6_grants", glog.size(), 80);
    chk("t6_fair", (g0 - g1 <= 1) && (g1 - g0 <= 1), 1);
    chk("t6_pkt_cnt", pkt_cnt, 82);
    chk("t6_trunc", trunc_n, 1);
    chk("t6_wr_while_full", wf, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
